// File: rtl/hamming_enc_rr_arbiter_pkg.sv
// Shared definitions for the SECDED(8,4) Hamming encoder and its users.
// HAM_DW / HAM_CW give the data and codeword widths. The bit-position
// constants place each Hamming position (1..7) and the overall parity bit
// inside the 8-bit codeword, so a matching decoder can reuse the same map.
package hamming_enc_rr_arbiter_pkg;

   localparam int HAM_DW = 4;
   localparam int HAM_CW = 8;

   // Codeword bit positions: c[0..6] are Hamming positions 1..7, c[7] is overall parity.
   localparam int P1   = 0;
   localparam int P2   = 1;
   localparam int D0   = 2;
   localparam int P4   = 3;
   localparam int D1   = 4;
   localparam int D2   = 5;
   localparam int D3   = 6;
   localparam int PALL = 7;

endpackage

// File: rtl/hamming_secded_enc84.sv
// Combinational SECDED(8,4) Hamming encoder.
// Ports:
//   data_i  [3:0]  data nibble d[3:0]
//   code_o  [7:0]  codeword. The Hamming positions sit at c[6:0]; c[7] makes the whole word even parity.
module hamming_secded_enc84
   import hamming_enc_rr_arbiter_pkg::*;
(
   input  logic [HAM_DW-1:0] data_i,
   output logic [HAM_CW-1:0] code_o
);

   logic [HAM_CW-2:0] ham_w;

   always_comb begin
      ham_w     = '0;
      ham_w[D0] = data_i[0];
      ham_w[D1] = data_i[1];
      ham_w[D2] = data_i[2];
      ham_w[D3] = data_i[3];
      ham_w[P1] = data_i[0] ^ data_i[1] ^ data_i[3];
      ham_w[P2] = data_i[0] ^ data_i[2] ^ data_i[3];
      ham_w[P4] = data_i[1] ^ data_i[2] ^ data_i[3];
   end

   assign code_o = {^ham_w, ham_w};

endmodule

// File: rtl/hamming_enc_rr_arbiter.sv
// Round-robin arbiter that shares one SECDED(8,4) encoder among N_REQ nibble
// sources. It feeds a single registered output stage that has valid/ready
// backpressure.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             grants allowed when 1. The output stage always drains.
//   req_valid      per-requester valid
//   req_data       nibble i at [4i+3:4i]
//   req_ready      one-hot grant, or zero when nothing loads this cycle
//   out_valid      the output register holds a word
//   out_code       encoded word
//   out_id         requester index of out_code
//   out_ready      the sink takes the word when out_valid & out_ready
//   enc_count      count of accepted nibbles, modulo 2**CNTW
module hamming_enc_rr_arbiter
   import hamming_enc_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW   = 2,
   parameter int CNTW  = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [HAM_DW*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [HAM_CW-1:0]       out_code,
   output logic [IDW-1:0]          out_id,
   input  logic                    out_ready,
   output logic [CNTW-1:0]         enc_count
);

   localparam logic [IDW:0] NR = (IDW+1)'(N_REQ);

   logic              out_valid_q, out_valid_d;
   logic [HAM_CW-1:0] out_code_q,  out_code_d;
   logic [IDW-1:0]    out_id_q,    out_id_d;
   logic [IDW-1:0]    ptr_q,       ptr_d;
   logic [CNTW-1:0]   cnt_q,       cnt_d;

   // cand_idx[k] is the requester checked at scan step k, i.e. (ptr + k) mod N_REQ.
   logic [IDW-1:0]    cand_idx [N_REQ];
   logic [N_REQ-1:0]  rot_valid;
   logic [IDW-1:0]    grant_idx;
   logic              load;
   logic [HAM_DW-1:0] enc_in;
   logic [HAM_CW-1:0] enc_out;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_scan
         localparam logic [IDW:0] OFF = (IDW+1)'(gi);
         logic [IDW:0] sum_w;
         assign sum_w         = {1'b0, ptr_q} + OFF;
         assign cand_idx[gi]  = (sum_w >= NR) ? IDW'(sum_w - NR) : IDW'(sum_w);
         assign rot_valid[gi] = req_valid[cand_idx[gi]];
      end
   endgenerate

   // First valid requester at or after the pointer. The index is not used unless some request is valid.
   always_comb begin
      grant_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) grant_idx = cand_idx[k];
      end
   end

   // A drain and a load can happen on the same edge, so a full-rate sink leaves no bubble.
   // rst is included so that req_ready stays low for the whole reset.
   assign load = ~rst & en & (|req_valid) & (~out_valid_q | out_ready);

   assign req_ready = load ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

   // Each nibble is 4 bits wide, so its base bit offset is grant_idx * 4.
   assign enc_in = req_data[{grant_idx, 2'b00} +: HAM_DW];

   hamming_secded_enc84 u_enc (
      .data_i (enc_in),
      .code_o (enc_out)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_id_d    = out_id_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_code_d  = enc_out;
         out_id_d    = grant_idx;
         ptr_d       = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
         cnt_d       = cnt_q + 1'b1;
      end else if (out_valid_q && out_ready) begin
         // The code and id keep their stale values. Only valid drops.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_id_q    <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_id_q    <= out_id_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_id    = out_id_q;
   assign enc_count = cnt_q;

endmodule

// File: tb/tb_hamming_enc_rr_arbiter.sv
module tb_hamming_enc_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [7:0]  out_code;
   logic [1:0]  out_id;
   logic        out_ready;
   logic [15:0] enc_count;

   // Second instance with a 4-bit counter. It shares the stimulus and is used for the wrap test.
   logic [3:0]  w_req_ready;
   logic        w_out_valid;
   logic [7:0]  w_out_code;
   logic [1:0]  w_out_id;
   logic [3:0]  w_enc_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hamming_enc_rr_arbiter #(.N_REQ(4), .IDW(2), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_code(out_code),
      .out_id(out_id), .out_ready(out_ready), .enc_count(enc_count)
   );

   hamming_enc_rr_arbiter #(.N_REQ(4), .IDW(2), .CNTW(4)) dut_w (
      .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
      .req_ready(w_req_ready), .out_valid(w_out_valid), .out_code(w_out_code),
      .out_id(w_out_id), .out_ready(out_ready), .enc_count(w_enc_count)
   );

   // Encoding written directly from the codeword equations.
   function automatic logic [7:0] ref_enc(input logic [3:0] d);
      logic [6:0] h;
      h[0] = d[0] ^ d[1] ^ d[3];
      h[1] = d[0] ^ d[2] ^ d[3];
      h[2] = d[0];
      h[3] = d[1] ^ d[2] ^ d[3];
      h[4] = d[1];
      h[5] = d[2];
      h[6] = d[3];
      return {^h, h};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; en = 1'b1; req_valid = '0; out_ready = 1'b0; req_data = 16'hD6B1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; req_valid = 4'hF; out_ready = 1'b1; req_data = 16'hD6B1;
      #1;
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_code !== 8'h00) begin n_err++; $display("FAIL rst_out_code got=%h exp=00", out_code); end
      n_vec++; if (out_id !== 2'd0) begin n_err++; $display("FAIL rst_out_id got=%0d exp=0", out_id); end
      n_vec++; if (enc_count !== 16'd0) begin n_err++; $display("FAIL rst_enc_count got=%0d exp=0", enc_count); end
      rst = 1'b0; req_valid = '0;
   endtask

   task automatic test_encoder();
      logic [3:0] hd [4];
      logic [7:0] hc [4];
      hd = '{4'h0, 4'h1, 4'hB, 4'hF};
      hc = '{8'h00, 8'h87, 8'h55, 8'hFF};
      apply_reset();
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         req_valid = 4'b0001; req_data = {12'h000, hd[j]};
         tick();
         $display("txn enc hand d=%h code=%h id=%0d", hd[j], out_code, out_id);
         n_vec++; if (out_code !== hc[j] || out_valid !== 1'b1) begin n_err++; $display("FAIL enc_hand d=%h got=%h v=%b exp=%h v=1", hd[j], out_code, out_valid, hc[j]); end
      end
      for (int d = 0; d < 16; d++) begin
         req_valid = 4'b0001; req_data = {12'h000, 4'(d)};
         tick();
         $display("txn enc d=%h code=%h id=%0d", 4'(d), out_code, out_id);
         n_vec++; if (out_code !== ref_enc(4'(d)) || out_id !== 2'd0) begin n_err++; $display("FAIL enc_table d=%h got=%h id=%0d exp=%h id=0", 4'(d), out_code, out_id, ref_enc(4'(d))); end
      end
      req_valid = '0;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL enc_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_round_robin();
      logic [3:0] nib;
      apply_reset();
      req_valid = 4'hF; req_data = 16'hD6B1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_vec++; if (req_ready !== (4'b0001 << (i % 4))) begin n_err++; $display("FAIL rr_ready i=%0d got=%b exp=%b", i, req_ready, 4'b0001 << (i % 4)); end
         tick();
         nib = req_data[4*(i%4) +: 4];
         $display("txn rr i=%0d id=%0d code=%h", i, out_id, out_code);
         n_vec++; if (out_id !== 2'(i % 4) || out_valid !== 1'b1 || out_code !== ref_enc(nib)) begin n_err++; $display("FAIL rr_word i=%0d got id=%0d v=%b code=%h exp id=%0d v=1 code=%h", i, out_id, out_valid, out_code, i % 4, ref_enc(nib)); end
      end
      n_vec++; if (enc_count !== 16'd8) begin n_err++; $display("FAIL rr_count got=%0d exp=8", enc_count); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_valid = 4'hF; req_data = 16'hD6B1; out_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL bp_ready c=%0d got=%b exp=0000", i, req_ready); end
         tick();
         n_vec++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_code !== 8'h87 || enc_count !== 16'd1) begin n_err++; $display("FAIL bp_hold c=%0d got v=%b id=%0d code=%h cnt=%0d exp v=1 id=0 code=87 cnt=1", i, out_valid, out_id, out_code, enc_count); end
      end
      out_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
      tick();
      // Requester 1 has nibble 0xB, which encodes to 0x55.
      n_vec++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_code !== 8'h55 || enc_count !== 16'd2) begin n_err++; $display("FAIL bp_reload got v=%b id=%0d code=%h cnt=%0d exp v=1 id=1 code=55 cnt=2", out_valid, out_id, out_code, enc_count); end
      req_valid = '0;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_sparse();
      apply_reset();
      out_ready = 1'b1; req_data = 16'hD6B1;
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0001;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sparse_ready0 got=%b exp=0001", req_ready); end
      tick();
      n_vec++; if (out_id !== 2'd0) begin n_err++; $display("FAIL sparse_id0 got=%0d exp=0", out_id); end
      req_valid = 4'b1010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL sparse_ready1 got=%b exp=0010", req_ready); end
      tick();
      n_vec++; if (out_id !== 2'd1 || out_code !== 8'h55) begin n_err++; $display("FAIL sparse_id1 got id=%0d code=%h exp id=1 code=55", out_id, out_code); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_enable();
      apply_reset();
      req_data = 16'hD6B1; req_valid = 4'b0100; out_ready = 1'b0;
      tick();
      en = 1'b0; req_valid = 4'hF;
      #1;
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL en_ready got=%b exp=0000", req_ready); end
      tick();
      n_vec++; if (enc_count !== 16'd1 || out_valid !== 1'b1 || out_id !== 2'd2 || out_code !== ref_enc(4'h6)) begin n_err++; $display("FAIL en_hold got cnt=%0d v=%b id=%0d code=%h exp cnt=1 v=1 id=2 code=%h", enc_count, out_valid, out_id, out_code, ref_enc(4'h6)); end
      out_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL en_ready_drain got=%b exp=0000", req_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b0 || enc_count !== 16'd1 || out_id !== 2'd2) begin n_err++; $display("FAIL en_drain got v=%b cnt=%0d id=%0d exp v=0 cnt=1 id=2", out_valid, enc_count, out_id); end
      en = 1'b1; req_valid = '0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_data = 16'hD6B1; req_valid = 4'hF; out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_id !== 2'd1 || enc_count !== 16'd2) begin n_err++; $display("FAIL mid_pre got v=%b id=%0d cnt=%0d exp v=1 id=1 cnt=2", out_valid, out_id, enc_count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if (out_valid !== 1'b0 || enc_count !== 16'd0) begin n_err++; $display("FAIL mid_rst got v=%b cnt=%0d exp v=0 cnt=0", out_valid, enc_count); end
      out_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
      tick();
      n_vec++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_grant got id=%0d v=%b exp id=0 v=1", out_id, out_valid); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_counter_wrap();
      apply_reset();
      req_data = 16'hD6B1; req_valid = 4'b0001; out_ready = 1'b1;
      for (int i = 0; i < 17; i++) tick();
      n_vec++; if (w_enc_count !== 4'd1) begin n_err++; $display("FAIL wrap_cnt4 got=%0d exp=1", w_enc_count); end
      n_vec++; if (enc_count !== 16'd17) begin n_err++; $display("FAIL wrap_cnt16 got=%0d exp=17", enc_count); end
      req_valid = '0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
      tick();
      test_reset();
      test_encoder();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_enable();
      test_reset_mid();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
